// File: rtl/aes_inv_cipher_iter.sv
// -----------------------------------------------------------------------------
// aes_inv_cipher_iter
//   Iterative AES inverse cipher, one round per clock. Ciphertext comes in on a
//   valid/ready handshake, plaintext leaves on another. Round keys come from an
//   external key-schedule store: o_key_round selects the key, and i_key_in must
//   return it combinationally in the same cycle.
//
//   Parameter NR : 10 / 12 / 14 (AES-128/192/256). Any other value stops elaboration.
//
//   Ports
//     i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//     i_in_valid / o_in_ready ciphertext handshake
//     i_data_in   [127:0]     ciphertext, byte0 = [127:120], s[r,c] = byte[r+4c]
//     o_key_round [3:0]       round-key index needed this cycle (NR/rnd/0)
//     i_key_in    [127:0]     round key for o_key_round
//     o_out_valid / i_out_ready plaintext handshake
//     o_data_out  [127:0]     plaintext, same byte order as i_data_in
//
//   Build option AES_DEC_ZEROIZE_EN: when defined, the state register (and
//   therefore o_data_out) clears on the output handshake edge.
// -----------------------------------------------------------------------------

// One InvSubBytes lane: 256-entry inverse S-box ROM.
module aes_inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    // The first table entry lands in element 255, so index with ~x (== 255-x).
    localparam logic [255:0][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    assign o_byte = INV_SBOX[~i_byte];
endmodule

// One InvMixColumns column: [0e 0b 0d 09] circulant built from xtime chains.
module aes_inv_mixcol (
    input  logic [31:0] i_col,   // row0 in [31:24]
    output logic [31:0] o_col
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
    endfunction

    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            logic [7:0] x2, x4, x8;
            a[r]  = i_col[31-8*r -: 8];
            x2    = xt(a[r]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
    end

    assign o_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                    m9[0] ^ me[1] ^ mb[2] ^ md[3],
                    md[0] ^ m9[1] ^ me[2] ^ mb[3],
                    mb[0] ^ md[1] ^ m9[2] ^ me[3]};
endmodule

module aes_inv_cipher_iter #(
    parameter int NR = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [127:0] i_data_in,
    output logic [3:0]   o_key_round,
    input  logic [127:0] i_key_in,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_data_out
);
    generate
        if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
            $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
        end
    endgenerate

    localparam logic [3:0] NR_L  = 4'(NR);
    localparam logic [3:0] NR_M1 = 4'(NR - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd2} state_t;

    state_t         r_state, w_state_nxt;
    logic [3:0]     r_rnd, w_rnd_nxt;
    logic [127:0]   r_st, w_st_nxt;

    // Round datapath. Packed element 15-k holds byte k (byte0 is the MSB).
    logic [15:0][7:0] w_st_b, w_isr, w_isb;
    logic [127:0]     w_ark, w_imc;

    assign w_st_b = r_st;

    // InvShiftRows: row r rotates right by r, i.e. s'[r,(c+r)%4] = s[r,c].
    always_comb begin
        w_isr = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                w_isr[15 - (r + 4*((c + r) % 4))] = w_st_b[15 - (r + 4*c)];
    end

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_sbox
            aes_inv_sbox u_sbox (.i_byte(w_isr[g]), .o_byte(w_isb[g]));
        end
    endgenerate

    assign w_ark = w_isb ^ i_key_in;

    generate
        for (g = 0; g < 4; g++) begin : g_mix
            aes_inv_mixcol u_mix (.i_col(w_ark[127-32*g -: 32]), .o_col(w_imc[127-32*g -: 32]));
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_rnd   <= '0;
            r_st    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rnd   <= w_rnd_nxt;
            r_st    <= w_st_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rnd_nxt   = r_rnd;
        w_st_nxt    = r_st;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_key_round = 4'd0;
        unique case (r_state)
            S_IDLE: begin
                o_in_ready  = 1'b1;
                o_key_round = NR_L;
                if (i_in_valid) begin
                    w_st_nxt    = i_data_in ^ i_key_in;
                    w_rnd_nxt   = NR_M1;
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                o_key_round = r_rnd;
                if (r_rnd != 4'd0) begin
                    w_st_nxt  = w_imc;
                    w_rnd_nxt = r_rnd - 4'd1;
                end else begin
                    // Final round skips InvMixColumns.
                    w_st_nxt    = w_ark;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
`ifdef AES_DEC_ZEROIZE_EN
                    w_st_nxt    = '0;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_data_out = r_st;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: two instances (NR=10 and NR=14),
// each fed round keys from a key schedule built here from scratch.
module tb_aes_inv_cipher_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [127:0] data_in_a, key_in_a, data_out_a;
    logic [3:0]   key_round_a;
    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [127:0] data_in_b, key_in_b, data_out_b;
    logic [3:0]   key_round_b;

    logic [127:0] rka [16];
    logic [127:0] rkb [16];
    logic [7:0]   sbox [256];

    assign key_in_a = rka[key_round_a];
    assign key_in_b = rkb[key_round_b];

    aes_inv_cipher_iter #(.NR(10)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid_a), .o_in_ready(in_ready_a),
        .i_data_in(data_in_a), .o_key_round(key_round_a), .i_key_in(key_in_a),
        .o_out_valid(out_valid_a), .i_out_ready(out_ready_a), .o_data_out(data_out_a));

    aes_inv_cipher_iter #(.NR(14)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid_b), .o_in_ready(in_ready_b),
        .i_data_in(data_in_b), .o_key_round(key_round_b), .i_key_in(key_in_b),
        .o_out_valid(out_valid_b), .i_out_ready(out_ready_b), .o_data_out(data_out_b));

`ifdef AES_DEC_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // Forward S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, r1, r2, r3, r4;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r1 = {inv[6:0], inv[7]};
            r2 = {r1[6:0], r1[7]};
            r3 = {r2[6:0], r2[7]};
            r4 = {r3[6:0], r3[7]};
            sbox[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // Key expansion; key is left-aligned in 256 bits, nk = 4 or 8.
    task automatic expand(input logic [255:0] key, input int nk, input bit to_b);
        logic [31:0] w [64];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 64; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            logic [127:0] k;
            k = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
            if (to_b) rkb[r] = k; else rka[r] = k;
        end
    endtask

    // Push one block into instance A and retire it. The latency count includes
    // the accept cycle, so out_valid is seen on count NR+1.
    task automatic run_a(input logic [127:0] ct, input logic [127:0] pt, input string tag);
        int n;
        chk({tag, "_in_ready"}, 128'(in_ready_a), 128'd1);
        in_valid_a = 1'b1;
        data_in_a  = ct;
        tick();
        in_valid_a = 1'b0;
        data_in_a  = '0;
        n = 1;
        while (!out_valid_a && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'd11);
        chk({tag, "_pt"}, data_out_a, pt);
        chk({tag, "_busy"}, 128'(in_ready_a), 128'd0);
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        chk({tag, "_ov_drop"}, 128'(out_valid_a), 128'd0);
        chk({tag, "_idle"}, 128'(in_ready_a), 128'd1);
        chk({tag, "_post"}, data_out_a, ZEROIZE ? 128'h0 : pt);
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        in_valid_a = 0; out_ready_a = 0; data_in_a = '0;
        in_valid_b = 0; out_ready_b = 0; data_in_b = '0;
        for (int i = 0; i < 16; i++) begin rka[i] = '0; rkb[i] = '0; end
        build_sbox();
        expand({C1_KEY, 128'h0}, 4, 1'b0);

        // Reset state
        #2;
        chk("rst_in_ready", 128'(in_ready_a), 128'd1);
        chk("rst_out_valid", 128'(out_valid_a), 128'd0);
        chk("rst_data_out", data_out_a, 128'h0);
        chk("rst_key_round", 128'(key_round_a), 128'd10);
        chk("rst_key_round14", 128'(key_round_b), 128'd14);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // FIPS-197 C.1
        run_a(C1_CT, C1_PT, "c1");

        // FIPS-197 App B with per-cycle key_round and a long output stall
        expand({B_KEY, 128'h0}, 4, 1'b0);
        chk("b_kr_idle", 128'(key_round_a), 128'd10);
        in_valid_a = 1'b1;
        data_in_a  = B_CT;
        tick();
        in_valid_a = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            chk("b_kr_round", 128'(key_round_a), 128'(i));
            chk("b_ov_low", 128'(out_valid_a), 128'd0);
            tick();
        end
        chk("b_ov", 128'(out_valid_a), 128'd1);
        chk("b_pt", data_out_a, B_PT);
        chk("b_kr_done", 128'(key_round_a), 128'd0);
        for (int i = 0; i < 20; i++) begin
            in_valid_a = i[0];
            data_in_a  = {4{$urandom}};
            tick();
            chk("stall_ov", 128'(out_valid_a), 128'd1);
            chk("stall_pt", data_out_a, B_PT);
            chk("stall_busy", 128'(in_ready_a), 128'd0);
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        chk("b_ov_drop", 128'(out_valid_a), 128'd0);
        chk("b_idle", 128'(in_ready_a), 128'd1);
        chk("b_kr_back", 128'(key_round_a), 128'd10);
        chk("b_post", data_out_a, ZEROIZE ? 128'h0 : B_PT);

        // Reset in the middle of a block
        expand({C1_KEY, 128'h0}, 4, 1'b0);
        in_valid_a = 1'b1;
        data_in_a  = C1_CT;
        tick();
        in_valid_a = 1'b0;
        n = 0;
        while (key_round_a != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        chk("mid_reach_r5", 128'(key_round_a), 128'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_ov", 128'(out_valid_a), 128'd0);
        chk("mid_data", data_out_a, 128'h0);
        chk("mid_in_ready", 128'(in_ready_a), 128'd1);
        chk("mid_kr", 128'(key_round_a), 128'd10);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mid_no_out", 128'(out_valid_a), 128'd0);
        run_a(C1_CT, C1_PT, "c1_again");

        // FIPS-197 C.3 on the NR=14 instance
        expand(C3_KEY, 8, 1'b1);
        chk("c3_kr_idle", 128'(key_round_b), 128'd14);
        in_valid_b = 1'b1;
        data_in_b  = C3_CT;
        tick();
        in_valid_b = 1'b0;
        n = 1;
        while (!out_valid_b && n < 40) begin
            tick();
            n++;
        end
        chk("c3_latency", 128'(n), 128'd15);
        chk("c3_pt", data_out_b, C1_PT);
        out_ready_b = 1'b1;
        tick();
        out_ready_b = 1'b0;
        chk("c3_ov_drop", 128'(out_valid_b), 128'd0);
        chk("c3_post", data_out_b, ZEROIZE ? 128'h0 : C1_PT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
